// File: rtl/id_ctrl_hazard_unit_pkg.sv
// Shared encodings for the ID-stage control/hazard slice: opcodes, control bundle layout, FSM states.
package id_ctrl_hazard_unit_pkg;

  localparam logic [6:0] R_OPCODE      = 7'b0110011;
  localparam logic [6:0] B_OPCODE      = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE    = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE   = 7'b1100111;
  localparam logic [6:0] IALU_OPCODE   = 7'b0010011;
  localparam logic [6:0] LOAD_OPCODE   = 7'b0000011;
  localparam logic [6:0] S_OPCODE      = 7'b0100011;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam int CTRL_BUNDLE_WIDTH = 8;

  // Bundle bit positions, MSB first: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,MulDiv}
  localparam int CB_ALUSRC   = 7;
  localparam int CB_MEMTOREG = 6;
  localparam int CB_REGWRITE = 5;
  localparam int CB_MEMREAD  = 4;
  localparam int CB_MEMWRITE = 3;
  localparam int CB_BRANCH   = 2;
  localparam int CB_JUMP     = 1;
  localparam int CB_MULDIV   = 0;

  typedef logic [CTRL_BUNDLE_WIDTH-1:0] ctrl_bundle_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/id_ctrl_hazard_unit_ctrl_decode.sv
// Purely combinational opcode/funct7 decode into the control bundle plus source-register usage.
module ctrl_decode
  import id_ctrl_hazard_unit_pkg::*;
#(
  parameter int OPCODE_WIDTH = 7,
  parameter int USE_MULDIV   = 1
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [6:0]              funct7,
  output ctrl_bundle_t            bundle,
  output logic                    uses_rs1,
  output logic                    uses_rs2,
  output logic                    illegal
);

  logic [6:0] op7;
  assign op7 = 7'(opcode);

  always_comb begin
    bundle   = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (op7)
      R_OPCODE: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_MULDIV]   = (USE_MULDIV != 0) && (funct7 == MULDIV_FUNCT7);
        uses_rs1            = 1'b1;
        uses_rs2            = 1'b1;
      end
      B_OPCODE: begin
        bundle[CB_BRANCH] = 1'b1;
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
      end
      JAL_OPCODE: begin
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_JUMP]     = 1'b1;
      end
      JALR_OPCODE: begin
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_JUMP]     = 1'b1;
        uses_rs1            = 1'b1;
      end
      IALU_OPCODE: begin
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_REGWRITE] = 1'b1;
        uses_rs1            = 1'b1;
      end
      LOAD_OPCODE: begin
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_MEMTOREG] = 1'b1;
        bundle[CB_REGWRITE] = 1'b1;
        bundle[CB_MEMREAD]  = 1'b1;
        uses_rs1            = 1'b1;
      end
      S_OPCODE: begin
        bundle[CB_ALUSRC]   = 1'b1;
        bundle[CB_MEMWRITE] = 1'b1;
        uses_rs1            = 1'b1;
        uses_rs2            = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ctrl_hazard_unit.sv
// ID-stage control: decode, load-use / multi-cycle MUL/DIV stall, flush bubbles, ID/EX control register.
module id_ctrl_hazard_unit
  import id_ctrl_hazard_unit_pkg::*;
#(
  parameter int OPCODE_WIDTH   = 7,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int USE_MULDIV     = 1,
  parameter int MULDIV_LAT     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inst_valid,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic [6:0]                funct7,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_memread,
  input  logic                      flush,
  output logic                      stall_if,
  output logic                      ex_valid,
  output logic                      ex_ALUSrc,
  output logic                      ex_MemtoReg,
  output logic                      ex_RegWrite,
  output logic                      ex_MemRead,
  output logic                      ex_MemWrite,
  output logic                      ex_Branch,
  output logic                      ex_Jump,
  output logic                      ex_MulDiv,
  output logic                      ex_illegal,
  output logic                      muldiv_busy
);

  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  ctrl_bundle_t dec_bundle;
  logic         uses_rs1, uses_rs2, illegal;

  ctrl_decode #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .USE_MULDIV   (USE_MULDIV)
  ) u_decode (
    .opcode   (opcode),
    .funct7   (funct7),
    .bundle   (dec_bundle),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (illegal)
  );

  logic hz;
  assign hz = inst_valid && ex_memread && (ex_rd != '0) &&
              ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

  // Priority: flush > busy > load-use > normal issue
  logic issue, issue_md;
  assign issue    = !flush && !muldiv_busy && !hz;
  assign issue_md = issue && inst_valid && dec_bundle[CB_MULDIV];

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = ST_IDLE;
    end else if (issue_md) begin
      cnt_d   = LAT_M1;
      state_d = (LAT_M1 != 4'd0) ? ST_BUSY : ST_IDLE;
    end
  end

  always_comb begin
    muldiv_busy = (cnt_q != 4'd0);
    stall_if    = !flush && (hz || muldiv_busy);
  end

  // ID/EX control stage
  ctrl_bundle_t bundle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q   <= '0;
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (issue) begin
      bundle_q   <= inst_valid ? dec_bundle : '0;
      ex_valid   <= inst_valid;
      ex_illegal <= inst_valid && illegal;
    end else begin
      bundle_q   <= '0;
      ex_valid   <= 1'b0;
      ex_illegal <= 1'b0;
    end
  end

  assign ex_ALUSrc   = bundle_q[CB_ALUSRC];
  assign ex_MemtoReg = bundle_q[CB_MEMTOREG];
  assign ex_RegWrite = bundle_q[CB_REGWRITE];
  assign ex_MemRead  = bundle_q[CB_MEMREAD];
  assign ex_MemWrite = bundle_q[CB_MEMWRITE];
  assign ex_Branch   = bundle_q[CB_BRANCH];
  assign ex_Jump     = bundle_q[CB_JUMP];
  assign ex_MulDiv   = bundle_q[CB_MULDIV];

endmodule
